// File: rtl/mul_div16_pkg.sv
// Shared types and defaults for the execute-stage iterative multiply/divide unit.
package mul_div16_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 5;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/mul_div16_if.sv
// Issue/result bundle between pipeline control and the multiply/divide unit.
interface mul_div16_if #(
  parameter int unsigned WIDTH = mul_div16_pkg::WIDTH
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, div_by_zero
  );

endinterface

// File: rtl/mul_div16.sv
// Iterative unsigned WIDTHxWIDTH multiplier / WIDTH/WIDTH restoring divider
// sharing one 2*WIDTH+1-bit accumulator; one iteration per clock.
module mul_div16
  import mul_div16_pkg::*;
#(
  parameter int unsigned WIDTH = mul_div16_pkg::WIDTH,
  parameter int unsigned CNT_W = mul_div16_pkg::CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  mul_div16_if.slave  bus
);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH:0]   r_acc;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic               r_dbz;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH:0]   w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH+1:0]   w_trial;
  logic [2*WIDTH:0]   w_div_next;
  logic [2*WIDTH:0]   w_acc_next;
  logic               w_last;

  // r_opnd holds the multiplicand for MUL and the divisor for DIV; the other
  // operand lives in the low half of r_acc and is consumed one bit per step.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    w_mul_next = r_acc[0] ? {1'b0, w_mul_sum, r_acc[WIDTH-1:1]}
                          : {1'b0, r_acc[2*WIDTH:1]};

    w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_trial    = {1'b0, w_rem_sh} - {2'b00, r_opnd};
    w_div_next = w_trial[WIDTH+1] ? {w_rem_sh, r_acc[WIDTH-2:0], 1'b0}
                                  : {w_trial[WIDTH:0], r_acc[WIDTH-2:0], 1'b1};

    w_acc_next = (r_op == OP_DIV) ? w_div_next : w_mul_next;
    w_last     = (r_cnt == CNT_W'(WIDTH-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_MUL;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op  <= bus.op;
            r_cnt <= '0;
            if (bus.op == OP_DIV && bus.b == '0) begin
              r_state <= S_DONE;
              r_lo    <= '1;
              r_hi    <= bus.a;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_opnd  <= (bus.op == OP_DIV) ? bus.b : bus.a;
              r_acc   <= {{(WIDTH+1){1'b0}}, (bus.op == OP_DIV) ? bus.a : bus.b};
            end
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_dbz   <= 1'b0;
            r_lo    <= w_acc_next[WIDTH-1:0];
            r_hi    <= w_acc_next[2*WIDTH-1:WIDTH];
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.result_lo   = r_lo;
  assign bus.result_hi   = r_hi;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_mul_div16.sv
// Randomized self-checking bench for mul_div16 against a plain-arithmetic model.
module tb_mul_div16;
  import mul_div16_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mul_div16_if #(.WIDTH(16)) bus ();

  mul_div16 #(.WIDTH(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [15:0] prev_lo  = '0;
  logic [15:0] prev_hi  = '0;
  logic        prev_dbz = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] lo, output logic [15:0] hi,
                                output logic dbz);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint unsigned p;
    if (op == 1'b0) begin
      p   = ua * ub;
      lo  = p[15:0];
      hi  = p[31:16];
      dbz = 1'b0;
    end else if (ub == 0) begin
      lo  = 16'hFFFF;
      hi  = a;
      dbz = 1'b1;
    end else begin
      p   = ua / ub;
      lo  = p[15:0];
      p   = ua % ub;
      hi  = p[15:0];
      dbz = 1'b0;
    end
  endfunction

  // inj_at > 0 pulses a conflicting DIV 9/3 request that many edges after acceptance.
  task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                        input int unsigned inj_at, input string tag);
    logic [15:0] m_lo, m_hi;
    logic        m_dbz;
    int unsigned lat      = 0;
    int unsigned busy_cnt = 0;
    bit          seen     = 0;
    model(op, a, b, m_lo, m_hi, m_dbz);

    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 1'($urandom);
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);

    for (int unsigned k = 0; k <= 40; k++) begin
      check({tag, "_excl"}, {31'd0, bus.busy & bus.done}, 32'd0);
      if (bus.done) begin
        lat  = k;
        seen = 1;
        break;
      end
      if (k == 0)
        check({tag, "_hold"}, {bus.result_hi, bus.result_lo}, {prev_hi, prev_lo});
      if (bus.busy) busy_cnt++;
      if (inj_at != 0 && k == inj_at) begin
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 16'd9; bus.b = 16'd3;
      end
      if (inj_at != 0 && k == inj_at + 1) bus.start = 1'b0;
      @(posedge clk);
      #1;
    end

    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      bus.start = 1'b0;
      return;
    end

    check({tag, "_lat"},  lat,      m_dbz ? 32'd0 : 32'd16);
    check({tag, "_busy"}, busy_cnt, m_dbz ? 32'd0 : 32'd16);
    check({tag, "_res"},  {bus.result_hi, bus.result_lo}, {m_hi, m_lo});
    check({tag, "_dbz"},  {31'd0, bus.div_by_zero}, {31'd0, m_dbz});
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
    check({tag, "_keep"},  {bus.result_hi, bus.result_lo}, {m_hi, m_lo});
    prev_lo  = m_lo;
    prev_hi  = m_hi;
    prev_dbz = m_dbz;
  endtask

  initial begin
    logic        rop;
    logic [15:0] ra, rb;

    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    #1;
    check("reset_out", {bus.result_hi, bus.result_lo}, 32'd0);
    check("reset_flags", {29'd0, bus.busy, bus.done, bus.div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 16'd3,      16'd5,      0, "mul3x5");
    run_op(1'b0, 16'hFFFF,   16'hFFFF,   0, "mulmax");
    run_op(1'b1, 16'd100,    16'd7,      0, "div100_7");
    run_op(1'b1, 16'd5,      16'd9,      0, "div5_9");
    run_op(1'b1, 16'h1234,   16'd0,      0, "div0");
    run_op(1'b0, 16'd3,      16'd5,      4, "mul_ignore");
    run_op(1'b1, 16'd9,      16'd3,      0, "div9_3");
    run_op(1'b1, 16'hFFFF,   16'd1,      0, "div_by1");
    run_op(1'b1, 16'd0,      16'd0,      0, "div0_0");
    run_op(1'b0, 16'd0,      16'hBEEF,   0, "mul_zero");
    run_op(1'b1, 16'h8000,   16'hFFFF,   0, "div_big");

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'h1234; bus.b = 16'h5678;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out", {bus.result_hi, bus.result_lo}, 32'd0);
    check("arst_flags", {29'd0, bus.busy, bus.done, bus.div_by_zero}, 32'd0);
    for (int unsigned k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("arst_nodone", {31'd0, bus.done}, 32'd0);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    prev_lo  = '0;
    prev_hi  = '0;
    prev_dbz = 1'b0;
    run_op(1'b0, 16'd2, 16'd2, 0, "mul2x2");

    for (int unsigned i = 0; i < 150; i++) begin
      rop = 1'($urandom);
      ra  = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'd0;
        1:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      run_op(rop, ra, rb, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
